hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
- Central hazard controller for the 5-stage pipelined CPU.
- Keeps a shadow scoreboard of destination and control tags for the EX, MEM and WB stages.
- Drives EX operand forwarding selects and MEM store-data forwarding.
- Detects load-use hazards and inserts one bubble.
- Freezes the whole pipeline while data memory is busy; counts stall cycles for performance monitoring.

Parameters:
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rs  in  1  ID instruction reads rs
- id_uses_rt  in  1  ID instruction reads rt
- id_dest  in  5  ID instruction write destination
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- id_memwrite  in  1  ID instruction is a store
- mem_busy  in  1  data memory not ready this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- idex_flush  out  1  load bubble (zero controls) into ID/EX
- pipe_en  out  1  global enable for ID/EX, EX/MEM, MEM/WB
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- fwd_b  out  2  EX operand B select, same encoding as fwd_a
- fwd_store  out  1  MEM store data taken from the WB result
- stall_count  out  CNT_W  saturating stall-cycle count

Behaviour:
- Shadow registers:
  - EX stage: rs, rt, uses_rs, uses_rt, dest, rw, mr, mw
  - MEM stage: dest, rw, mr, mw, rt
  - WB stage: dest, rw
- Shadow update rules:
  - Shadows advance on each clk edge when pipe_en=1; all hold when pipe_en=0.
  - When idex_flush=1 and pipe_en=1, EX shadow loads rw=mr=mw=uses_rs=uses_rt=0. MEM and WB advance normally.
- Reset (rst_n=0 at the edge): all shadows cleared, FSM to RUN, stall_count=0.
- Outputs while rst_n is low: pc_write=0, ifid_write=0, pipe_en=0, idex_flush=1, fwd_a=fwd_b=00, fwd_store=0.
- Reset mid-stall or mid-MEM_WAIT aborts the stall immediately.
- FSM states:
  - RUN: pipe_en=1.
  - MEM_WAIT: pipe_en=0, pc_write=0, ifid_write=0, idex_flush=0.
  - RUN -> MEM_WAIT: when (mem_mr or mem_mw) and mem_busy. This transition is Mealy: the freeze outputs assert in the same cycle mem_busy is first seen.
  - MEM_WAIT -> RUN: on the first cycle mem_busy=0. Outputs in that cycle are RUN values.
- Load-use hazard, evaluated in RUN:
  - Define rs_hit = id_uses_rs and id_rs==ex_dest.
  - Define rt_hit = id_uses_rt and id_rt==ex_dest.
  - hazard = ex_mr and ex_rw and ex_dest!=0 and (rs_hit or (rt_hit and not id_memwrite)).
  - A store whose data (rt) depends on the load does not stall; it is served later by fwd_store.
  - On hazard: pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle. The next cycle sees a bubble in EX, so there is no repeat.
- Priority: mem freeze overrides hazard. idex_flush=0 while frozen; hazard is re-evaluated after release.
- Forwarding (combinational from shadows; register 0 is never forwarded):
  - fwd_a=01 if mem_rw and mem_dest!=0 and ex_uses_rs and mem_dest==ex_rs.
  - Otherwise fwd_a=10 if the same test passes with the WB shadow.
  - Otherwise fwd_a=00. EX/MEM has priority over MEM/WB.
  - fwd_b: same rules using ex_rt and ex_uses_rt.
  - fwd_store = mem_mw and wb_rw and wb_dest!=0 and wb_dest==mem_rt.
- stall_count:
  - Increments by 1 on each cycle with rst_n=1 and pc_write=0.
  - Saturates at 2^CNT_W-1 with no wrap.

Test Plan:
- Reset then idle with all id_* zero -> pc_write=1, pipe_en=1, fwd_a=fwd_b=00, stall_count=0.
- add $3 then sub $4,$3,$3 in consecutive cycles -> in the sub's EX cycle fwd_a=fwd_b=01. With one nop in between -> 10. Destination $0 in either case -> 00.
- lw $5 then add $6,$5,$1 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1. Next cycle fwd_a=10. stall_count=1.
- lw $5 then sw $5,0($2) -> no stall. When the sw reaches MEM, fwd_store=1.
- lw in MEM with mem_busy high for 3 cycles, and a load-use pair pending in ID -> pipe_en=0 for 3 cycles, idex_flush=0 during the freeze. Then one bubble cycle. stall_count=4.
- rst_n driven low during MEM_WAIT -> next cycle in RUN, shadows cleared, stall_count=0.
- CNT_W=2 with 5 stall cycles -> stall_count saturates at 3.

Source files
------------

// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_control_unit
// Description : Central hazard controller for a 5-stage pipelined CPU.
//               Keeps shadow copies of the register tags and control bits
//               held in EX, MEM and WB. From these it produces the EX operand
//               forwarding selects and the MEM store-data forward. It inserts
//               one bubble on a load-use hazard. It freezes the pipeline while
//               data memory is busy. It also counts stall cycles in a
//               saturating counter.
// Ports       : clk, rst_n            - clock, synchronous active-low reset
//               id_*                  - fields of the instruction in ID
//               mem_busy              - data memory not ready this cycle
//               pc_write, ifid_write  - front-end enables
//               idex_flush            - load a bubble into ID/EX
//               pipe_en               - enable for ID/EX, EX/MEM, MEM/WB
//               fwd_a, fwd_b          - 00 regfile, 01 EX/MEM, 10 MEM/WB
//               fwd_store             - MEM store data from the WB result
//               stall_count           - saturating stall-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_control_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_flush,
  output logic             pipe_en,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_store,
  output logic [CNT_W-1:0] stall_count
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

  state_t r_state;

  // EX shadow
  logic [4:0] r_ex_rs;
  logic [4:0] r_ex_rt;
  logic [4:0] r_ex_dest;
  logic       r_ex_uses_rs;
  logic       r_ex_uses_rt;
  logic       r_ex_rw;
  logic       r_ex_mr;
  logic       r_ex_mw;
  // MEM shadow
  logic [4:0] r_mem_dest;
  logic [4:0] r_mem_rt;
  logic       r_mem_rw;
  logic       r_mem_mr;
  logic       r_mem_mw;
  // WB shadow
  logic [4:0] r_wb_dest;
  logic       r_wb_rw;

  logic w_freeze;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_hazard;
  logic w_a_mem;
  logic w_a_wb;
  logic w_b_mem;
  logic w_b_wb;

  // Entering MEM_WAIT is Mealy: the first busy cycle with a memory op in MEM
  // already freezes. Once waiting, only mem_busy decides the release.
  always_comb begin
    w_freeze = 1'b0;
    if (r_state == MEM_WAIT) begin
      w_freeze = mem_busy;
    end else begin
      w_freeze = (r_mem_mr | r_mem_mw) & mem_busy;
    end
  end

  // A store whose rt depends on the load is not a hazard; its data is
  // supplied later through fwd_store.
  assign w_rs_hit = id_uses_rs && (id_rs == r_ex_dest);
  assign w_rt_hit = id_uses_rt && (id_rt == r_ex_dest);
  assign w_hazard = r_ex_mr && r_ex_rw && (r_ex_dest != 5'd0) &&
                    (w_rs_hit || (w_rt_hit && !id_memwrite));

  // Freeze has priority over the load-use bubble.
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    idex_flush = 1'b1;
    pipe_en    = 1'b0;
    if (rst_n) begin
      pipe_en    = !w_freeze;
      pc_write   = !w_freeze && !w_hazard;
      ifid_write = !w_freeze && !w_hazard;
      idex_flush = !w_freeze && w_hazard;
    end
  end

  // Forwarding: register 0 is never forwarded. EX/MEM wins over MEM/WB.
  assign w_a_mem = r_mem_rw && (r_mem_dest != 5'd0) && r_ex_uses_rs && (r_mem_dest == r_ex_rs);
  assign w_a_wb  = r_wb_rw  && (r_wb_dest  != 5'd0) && r_ex_uses_rs && (r_wb_dest  == r_ex_rs);
  assign w_b_mem = r_mem_rw && (r_mem_dest != 5'd0) && r_ex_uses_rt && (r_mem_dest == r_ex_rt);
  assign w_b_wb  = r_wb_rw  && (r_wb_dest  != 5'd0) && r_ex_uses_rt && (r_wb_dest  == r_ex_rt);

  always_comb begin
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    fwd_store = 1'b0;
    if (rst_n) begin
      if (w_a_mem) begin
        fwd_a = 2'b01;
      end else if (w_a_wb) begin
        fwd_a = 2'b10;
      end
      if (w_b_mem) begin
        fwd_b = 2'b01;
      end else if (w_b_wb) begin
        fwd_b = 2'b10;
      end
      fwd_store = r_mem_mw && r_wb_rw && (r_wb_dest != 5'd0) && (r_wb_dest == r_mem_rt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= RUN;
      stall_count  <= '0;
      r_ex_rs      <= 5'd0;
      r_ex_rt      <= 5'd0;
      r_ex_dest    <= 5'd0;
      r_ex_uses_rs <= 1'b0;
      r_ex_uses_rt <= 1'b0;
      r_ex_rw      <= 1'b0;
      r_ex_mr      <= 1'b0;
      r_ex_mw      <= 1'b0;
      r_mem_dest   <= 5'd0;
      r_mem_rt     <= 5'd0;
      r_mem_rw     <= 1'b0;
      r_mem_mr     <= 1'b0;
      r_mem_mw     <= 1'b0;
      r_wb_dest    <= 5'd0;
      r_wb_rw      <= 1'b0;
    end else begin
      case (r_state)
        RUN:      if (w_freeze) r_state <= MEM_WAIT;
        MEM_WAIT: if (!mem_busy) r_state <= RUN;
        default:  r_state <= RUN;
      endcase

      if (!pc_write && (stall_count != c_cnt_max)) begin
        stall_count <= stall_count + c_cnt_one;
      end

      if (pipe_en) begin
        // A flushed slot keeps its tags but loses every control bit.
        r_ex_rs      <= id_rs;
        r_ex_rt      <= id_rt;
        r_ex_dest    <= id_dest;
        r_ex_uses_rs <= id_uses_rs  && !idex_flush;
        r_ex_uses_rt <= id_uses_rt  && !idex_flush;
        r_ex_rw      <= id_regwrite && !idex_flush;
        r_ex_mr      <= id_memread  && !idex_flush;
        r_ex_mw      <= id_memwrite && !idex_flush;
        r_mem_dest   <= r_ex_dest;
        r_mem_rt     <= r_ex_rt;
        r_mem_rw     <= r_ex_rw;
        r_mem_mr     <= r_ex_mr;
        r_mem_mw     <= r_ex_mw;
        r_wb_dest    <= r_mem_dest;
        r_wb_rw      <= r_mem_rw;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_control_unit
// Description : Self-checking bench for hazard_control_unit. A record-based
//               pipeline model supplies the expected outputs for random
//               traffic. Directed scenarios are checked against constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread, id_memwrite;
  logic       mem_busy;

  logic        pc_write, ifid_write, idex_flush, pipe_en, fwd_store;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_count;

  logic        s_pc_write, s_ifid_write, s_idex_flush, s_pipe_en, s_fwd_store;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_flush(idex_flush),
    .pipe_en(pipe_en), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_store(fwd_store),
    .stall_count(stall_count)
  );

  hazard_control_unit #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .ifid_write(s_ifid_write), .idex_flush(s_idex_flush),
    .pipe_en(s_pipe_en), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .fwd_store(s_fwd_store),
    .stall_count(s_stall_count)
  );

  // --------------------------------------------------------------------------
  // Reference model: one instruction record per stage.
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0] rs, rt, dest;
    logic       urs, urt, rw, mr, mw;
  } instr_t;

  typedef struct packed {
    logic       pc_write, ifid_write, idex_flush, pipe_en;
    logic [1:0] fa, fb;
    logic       fs;
  } exp_t;

  instr_t m_ex, m_mem, m_wb;
  int     m_cnt;
  exp_t   m_e;

  function automatic instr_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt,
                                input logic [4:0] dest, input logic rw,
                                input logic mr, input logic mw);
    instr_t i;
    i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.dest = dest; i.rw = rw; i.mr = mr; i.mw = mw;
    return i;
  endfunction

  // Which older instruction produces register r: 1 = one ahead, 2 = two ahead.
  function automatic logic [1:0] producer(input logic [4:0] r, input logic used);
    if (!used || r == 5'd0) return 2'd0;
    if (m_mem.rw && m_mem.dest == r) return 2'd1;
    if (m_wb.rw && m_wb.dest == r) return 2'd2;
    return 2'd0;
  endfunction

  function automatic exp_t exp_out();
    exp_t e;
    logic frz, haz;
    e = '0;
    if (!rst_n) begin
      e.idex_flush = 1'b1;
      return e;
    end
    frz = (m_mem.mr || m_mem.mw) && mem_busy;
    haz = m_ex.mr && m_ex.rw && m_ex.dest != 5'd0 &&
          ((id_uses_rs && id_rs == m_ex.dest) ||
           (id_uses_rt && id_rt == m_ex.dest && !id_memwrite));
    e.pipe_en    = !frz;
    e.pc_write   = !frz && !haz;
    e.ifid_write = !frz && !haz;
    e.idex_flush = !frz && haz;
    e.fa = producer(m_ex.rs, m_ex.urs);
    e.fb = producer(m_ex.rt, m_ex.urt);
    e.fs = m_mem.mw && m_wb.rw && m_wb.dest != 5'd0 && m_wb.dest == m_mem.rt;
    return e;
  endfunction

  always @(posedge clk) begin
    m_e = exp_out();
    if (!rst_n) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0;
    end else begin
      if (!m_e.pc_write) m_cnt = m_cnt + 1;
      if (m_e.pipe_en) begin
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = mk(id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest,
                   id_regwrite, id_memread, id_memwrite);
        if (m_e.idex_flush) begin
          m_ex.urs = 1'b0; m_ex.urt = 1'b0;
          m_ex.rw = 1'b0; m_ex.mr = 1'b0; m_ex.mw = 1'b0;
        end
      end
    end
  end

  // Present one cycle of inputs at the falling edge, then let outputs settle.
  task automatic drive(input instr_t i, input logic busy, input logic rn);
    @(negedge clk);
    rst_n = rn;
    id_rs = i.rs; id_rt = i.rt; id_uses_rs = i.urs; id_uses_rt = i.urt;
    id_dest = i.dest; id_regwrite = i.rw; id_memread = i.mr; id_memwrite = i.mw;
    mem_busy = busy;
    #1;
  endtask

  task automatic do_reset();
    drive('0, 1'b0, 1'b0);
    drive('0, 1'b0, 1'b1);
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    drive('0, 1'b0, 1'b0);
    n_checks++;
    if ({pc_write, ifid_write, pipe_en, idex_flush, fwd_a, fwd_b, fwd_store} !== 9'b0001_0000_0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pc=%b ifid=%b en=%b flush=%b fa=%b fb=%b fs=%b, need 0 0 0 1 00 00 0",
               pc_write, ifid_write, pipe_en, idex_flush, fwd_a, fwd_b, fwd_store);
    end
    drive('0, 1'b0, 1'b1);
    n_checks++;
    if (pc_write !== 1'b1 || pipe_en !== 1'b1 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got pc=%b en=%b fa=%b fb=%b cnt=%0d, need 1 1 00 00 0",
               pc_write, pipe_en, fwd_a, fwd_b, stall_count);
    end
  endtask

  task automatic test_forwarding();
    logic [4:0] d;
    logic [1:0] want;
    for (int g = 0; g < 2; g++) begin
      for (int z = 0; z < 2; z++) begin
        d = (z == 1) ? 5'd0 : 5'd3;
        want = (z == 1) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
        repeat (3) drive('0, 1'b0, 1'b1);
        drive(mk(5'd1, 5'd2, 1'b1, 1'b1, d, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1);
        repeat (g) drive('0, 1'b0, 1'b1);
        drive(mk(d, d, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0), 1'b0, 1'b1);
        drive('0, 1'b0, 1'b1);
        n_checks++;
        if (fwd_a !== want || fwd_b !== want) begin
          n_fail++;
          $display("FAIL forward_gap%0d_dest%0d: got fa=%b fb=%b, need %b", g, d, fwd_a, fwd_b, want);
        end
      end
    end
  endtask

  task automatic test_load_use();
    instr_t add6;
    add6 = mk(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    do_reset();
    drive(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1);
    drive(add6, 1'b0, 1'b1);
    n_checks++;
    if ({pc_write, ifid_write, idex_flush, pipe_en} !== 4'b0011) begin
      n_fail++;
      $display("FAIL load_use_bubble: got pc=%b ifid=%b flush=%b en=%b, need 0 0 1 1",
               pc_write, ifid_write, idex_flush, pipe_en);
    end
    drive(add6, 1'b0, 1'b1);
    n_checks++;
    if ({pc_write, ifid_write, idex_flush} !== 3'b110) begin
      n_fail++;
      $display("FAIL load_use_single: got pc=%b ifid=%b flush=%b, need 1 1 0", pc_write, ifid_write, idex_flush);
    end
    drive('0, 1'b0, 1'b1);
    n_checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b00 || stall_count !== 16'd1) begin
      n_fail++;
      $display("FAIL load_use_forward: got fa=%b fb=%b cnt=%0d, need 10 00 1", fwd_a, fwd_b, stall_count);
    end
  endtask

  task automatic test_store_forward();
    do_reset();
    drive(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1);
    drive(mk(5'd2, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1), 1'b0, 1'b1);
    n_checks++;
    if (pc_write !== 1'b1 || idex_flush !== 1'b0) begin
      n_fail++;
      $display("FAIL store_no_stall: got pc=%b flush=%b, need 1 0", pc_write, idex_flush);
    end
    drive('0, 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1);
    n_checks++;
    if (fwd_store !== 1'b1) begin
      n_fail++;
      $display("FAIL store_forward: got fs=%b, need 1", fwd_store);
    end
  endtask

  task automatic test_mem_freeze();
    instr_t add6;
    add6 = mk(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    do_reset();
    drive(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1);
    drive(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      drive(add6, 1'b1, 1'b1);
      n_checks++;
      if ({pipe_en, pc_write, ifid_write, idex_flush} !== 4'b0000) begin
        n_fail++;
        $display("FAIL freeze_cycle%0d: got en=%b pc=%b ifid=%b flush=%b, need 0 0 0 0",
                 k, pipe_en, pc_write, ifid_write, idex_flush);
      end
    end
    drive(add6, 1'b0, 1'b1);
    n_checks++;
    if ({pipe_en, pc_write, idex_flush} !== 3'b101) begin
      n_fail++;
      $display("FAIL freeze_release_bubble: got en=%b pc=%b flush=%b, need 1 0 1", pipe_en, pc_write, idex_flush);
    end
    drive(add6, 1'b0, 1'b1);
    n_checks++;
    if (pc_write !== 1'b1 || idex_flush !== 1'b0 || stall_count !== 16'd4) begin
      n_fail++;
      $display("FAIL freeze_count: got pc=%b flush=%b cnt=%0d, need 1 0 4", pc_write, idex_flush, stall_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1);
    drive('0, 1'b1, 1'b1);
    n_checks++;
    if (pipe_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_entered: got en=%b, need 0", pipe_en);
    end
    drive('0, 1'b1, 1'b0);
    n_checks++;
    if ({pc_write, pipe_en, idex_flush} !== 3'b001) begin
      n_fail++;
      $display("FAIL wait_reset_outputs: got pc=%b en=%b flush=%b, need 0 0 1", pc_write, pipe_en, idex_flush);
    end
    drive('0, 1'b1, 1'b1);
    n_checks++;
    if (pipe_en !== 1'b1 || pc_write !== 1'b1 || stall_count !== 16'd0) begin
      n_fail++;
      $display("FAIL wait_reset_run: got en=%b pc=%b cnt=%0d, need 1 1 0", pipe_en, pc_write, stall_count);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(mk(5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b1);
    drive('0, 1'b0, 1'b1);
    repeat (5) drive('0, 1'b1, 1'b1);
    drive('0, 1'b0, 1'b1);
    n_checks++;
    if (s_stall_count !== 2'd3 || stall_count !== 16'd5) begin
      n_fail++;
      $display("FAIL count_saturate: got small=%0d wide=%0d, need 3 5", s_stall_count, stall_count);
    end
  endtask

  task automatic test_random();
    instr_t r;
    exp_t   e;
    logic   rn, busy;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      r.rs   = 5'($urandom_range(0, 3));
      r.rt   = 5'($urandom_range(0, 3));
      r.dest = 5'($urandom_range(0, 3));
      r.urs  = 1'($urandom_range(0, 1));
      r.urt  = 1'($urandom_range(0, 1));
      r.rw   = 1'($urandom_range(0, 1));
      r.mr   = ($urandom_range(0, 2) == 0);
      r.mw   = !r.mr && ($urandom_range(0, 3) == 0);
      busy   = ($urandom_range(0, 3) == 0);
      rn     = ($urandom_range(0, 49) != 0);
      drive(r, busy, rn);
      e = exp_out();
      n_checks++;
      if ({pc_write, ifid_write, idex_flush, pipe_en, fwd_a, fwd_b, fwd_store} !== e) begin
        n_fail++;
        $display("FAIL random_outputs cycle %0d: got %b, need %b", c,
                 {pc_write, ifid_write, idex_flush, pipe_en, fwd_a, fwd_b, fwd_store}, e);
      end
      n_checks++;
      if (stall_count !== 16'((m_cnt > 65535) ? 65535 : m_cnt) ||
          s_stall_count !== 2'((m_cnt > 3) ? 3 : m_cnt)) begin
        n_fail++;
        $display("FAIL random_count cycle %0d: got wide=%0d small=%0d, model count %0d",
                 c, stall_count, s_stall_count, m_cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    id_rs = '0; id_rt = '0; id_dest = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_regwrite = 1'b0;
    id_memread = 1'b0; id_memwrite = 1'b0; mem_busy = 1'b0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_store_forward();
    test_mem_freeze();
    test_reset_mid_wait();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
